// File: rtl/writeback_regfile_multi.sv
// LC3 writeback stage with a NUM_RD-port register file, PSR condition codes, write counter and sticky error.
// Optional same-cycle read forwarding is enabled by defining WRITEBACK_BYPASS_EN.
module writeback_regfile_multi #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_writeback,
    input  logic [1:0]               W_Control,
    input  logic [DATA_W-1:0]        aluout,
    input  logic [DATA_W-1:0]        memout,
    input  logic [DATA_W-1:0]        pcout,
    input  logic [ADDR_W-1:0]        dr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [2:0]               psr,
    output logic                     enableWB_status,
    output logic [CNT_W-1:0]         wb_count,
    output logic                     wb_err
);

    localparam logic [1:0] SEL_ALU     = 2'd0;
    localparam logic [1:0] SEL_MEM     = 2'd1;
    localparam logic [1:0] SEL_PC      = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    localparam logic [ADDR_W:0] REGS_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [2:0]      PSR_ZERO   = 3'b010;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [2:0]        psr_q, psr_d;
    logic              status_q, status_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] wb_value;
    logic              dr_in_range;
    logic              wr_accept;
    logic              wr_illegal;
    logic [NUM_REGS-1:0] wr_sel;

    // Source select; the illegal code never reaches the register file.
    always_comb begin
        wb_value = aluout;
        unique case (W_Control)
            SEL_ALU: wb_value = aluout;
            SEL_MEM: wb_value = memout;
            SEL_PC:  wb_value = pcout;
            default: wb_value = aluout;
        endcase
    end

    assign dr_in_range = ({1'b0, dr} < REGS_LIMIT);
    assign wr_illegal  = enable_writeback && (W_Control == SEL_ILLEGAL);
    assign wr_accept   = enable_writeback && !reset && (W_Control != SEL_ILLEGAL) && dr_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wsel
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            assign wr_sel[gi] = wr_accept && (dr == IDX);
        end
    endgenerate

    always_comb begin
        psr_d    = psr_q;
        status_d = wr_accept;
        count_d  = count_q;
        err_d    = err_q | wr_illegal;
        if (wr_accept) begin
            psr_d   = {wb_value[DATA_W-1],
                       (wb_value == '0),
                       !wb_value[DATA_W-1] && (wb_value != '0)};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wb_value;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            psr_q    <= PSR_ZERO;
            status_q <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            psr_q    <= psr_d;
            status_q <= status_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Independent read ports; addresses past the last register read as zero.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              addr_ok;
            logic [DATA_W-1:0] stored;

            assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
            assign addr_ok = ({1'b0, addr} < REGS_LIMIT);
            assign stored  = addr_ok ? regs_q[addr] : '0;

`ifdef WRITEBACK_BYPASS_EN
            assign rd_data[gi*DATA_W +: DATA_W] = (wr_accept && (addr == dr)) ? wb_value : stored;
`else
            assign rd_data[gi*DATA_W +: DATA_W] = stored;
`endif
        end
    endgenerate

    assign psr             = psr_q;
    assign enableWB_status = status_q;
    assign wb_count        = count_q;
    assign wb_err          = err_q;

endmodule

// File: tb/tb_writeback_regfile_multi.sv
// Randomised plus directed bench for writeback_regfile_multi against a behavioural register-file model.
module tb_writeback_regfile_multi;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int NUM_RD   = 3;
    localparam int CNT_W    = 4;
    localparam int ADDR_W   = 3;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable_writeback;
    logic [1:0]               W_Control;
    logic [DATA_W-1:0]        aluout, memout, pcout;
    logic [ADDR_W-1:0]        dr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [2:0]               psr;
    logic                     enableWB_status;
    logic [CNT_W-1:0]         wb_count;
    logic                     wb_err;

    always #5 clock = ~clock;

    writeback_regfile_multi #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
        .W_Control(W_Control), .aluout(aluout), .memout(memout), .pcout(pcout),
        .dr(dr), .rd_addr(rd_addr), .rd_data(rd_data), .psr(psr),
        .enableWB_status(enableWB_status), .wb_count(wb_count), .wb_err(wb_err)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [2:0]        m_psr;
    logic              m_status;
    int                m_count;
    logic              m_err;
    bit                m_valid = 1'b0;

    function automatic logic [DATA_W-1:0] src_value();
        if (W_Control == 2'd0) return aluout;
        if (W_Control == 2'd1) return memout;
        return pcout;
    endfunction

    function automatic bit accepted_now();
        return enable_writeback && !reset && (W_Control != 2'd3) && (int'(dr) < NUM_REGS);
    endfunction

    function automatic logic [2:0] flags_of(logic [DATA_W-1:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            m_psr    = 3'b010;
            m_status = 1'b0;
            m_count  = 0;
            m_err    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (accepted_now()) begin
                $display("wb  dr=%0d sel=%0d val=%h", dr, W_Control, src_value());
                m_regs[dr] = src_value();
                m_psr      = flags_of(src_value());
                m_status   = 1'b1;
                m_count    = (m_count + 1) % (1 << CNT_W);
            end else begin
                m_status = 1'b0;
                if (enable_writeback && W_Control == 2'd3) begin
                    $display("wb  illegal select dr=%0d", dr);
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            for (int k = 0; k < NUM_RD; k++) begin
                logic [ADDR_W-1:0] a;
                logic [DATA_W-1:0] exp;
                a   = rd_addr[k*ADDR_W +: ADDR_W];
                exp = m_regs[a];
`ifdef WRITEBACK_BYPASS_EN
                if (accepted_now() && a == dr) exp = src_value();
`endif
                check($sformatf("rd_data[%0d]", k), 32'(rd_data[k*DATA_W +: DATA_W]), 32'(exp));
            end
            check("psr", 32'(psr), 32'(m_psr));
            check("enableWB_status", 32'(enableWB_status), 32'(m_status));
            check("wb_count", 32'(wb_count), 32'(m_count));
            check("wb_err", 32'(wb_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] wc, input logic [DATA_W-1:0] v, input logic [ADDR_W-1:0] d);
        enable_writeback = 1'b1;
        W_Control        = wc;
        aluout           = 16'($urandom);
        memout           = 16'($urandom);
        pcout            = 16'($urandom);
        if (wc == 2'd0)      aluout = v;
        else if (wc == 2'd1) memout = v;
        else                 pcout  = v;
        dr = d;
    endtask

    task automatic setrd(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        int n;
        reset = 1'b1; enable_writeback = 1'b0; W_Control = 2'd0;
        aluout = '0; memout = '0; pcout = '0; dr = '0; rd_addr = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset after writes
        wr(2'd0, 16'h00AA, 3'd1); tick();
        wr(2'd1, 16'h1111, 3'd6); tick();
        enable_writeback = 1'b0;
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        setrd(0, 3'd1); setrd(1, 3'd6); setrd(2, 3'd0);
        #1;
        check("reset_r1", 32'(rd_data[15:0]), 32'h0);
        check("reset_r6", 32'(rd_data[31:16]), 32'h0);
        check("reset_psr", 32'(psr), 32'b010);
        check("reset_count", 32'(wb_count), 32'h0);
        check("reset_err", 32'(wb_err), 32'h0);
        check("reset_status", 32'(enableWB_status), 32'h0);

        // Sources and PSR
        wr(2'd0, 16'h8001, 3'd3); setrd(0, 3'd3); tick();
        enable_writeback = 1'b0; #1;
        check("alu_r3", 32'(rd_data[15:0]), 32'h8001);
        check("alu_psr", 32'(psr), 32'b100);
        check("alu_status", 32'(enableWB_status), 32'h1);
        wr(2'd1, 16'h0000, 3'd4); setrd(1, 3'd4); tick();
        enable_writeback = 1'b0; #1;
        check("mem_psr", 32'(psr), 32'b010);
        wr(2'd2, 16'h0005, 3'd5); setrd(1, 3'd5); tick();
        enable_writeback = 1'b0; #1;
        check("pc_r5", 32'(rd_data[31:16]), 32'h0005);
        check("pc_psr", 32'(psr), 32'b001);

        // Same-cycle read of the register being written
        wr(2'd0, 16'h0007, 3'd2); tick();
        wr(2'd0, 16'h1234, 3'd2); setrd(0, 3'd2); #1;
`ifdef WRITEBACK_BYPASS_EN
        check("same_cycle_read", 32'(rd_data[15:0]), 32'h1234);
`else
        check("same_cycle_read", 32'(rd_data[15:0]), 32'h0007);
`endif
        tick();
        enable_writeback = 1'b0; #1;
        check("next_cycle_read", 32'(rd_data[15:0]), 32'h1234);

        // Illegal select
        wr(2'd3, 16'hFFFF, 3'd1); aluout = 16'hFFFF; tick();
        enable_writeback = 1'b0; setrd(0, 3'd1); #1;
        check("illegal_r1", 32'(rd_data[15:0]), 32'h0);
        check("illegal_psr", 32'(psr), 32'b001);
        check("illegal_count", 32'(wb_count), 32'd5);
        check("illegal_err", 32'(wb_err), 32'h1);
        check("illegal_status", 32'(enableWB_status), 32'h0);
        tick(); tick(); tick();
        check("err_sticky", 32'(wb_err), 32'h1);

        // Counter wrap with idle cycles mixed in
        reset = 1'b1; tick(); reset = 1'b0;
        n = 0;
        while (n < 17) begin
            if ($urandom_range(0, 2) == 0) begin
                enable_writeback = 1'b0;
            end else begin
                wr(2'($urandom_range(0, 2)), 16'($urandom), 3'($urandom));
                n++;
            end
            tick();
        end
        enable_writeback = 1'b0; #1;
        check("wrap_count", 32'(wb_count), 32'd1);
        tick(); tick();
        check("idle_no_count", 32'(wb_count), 32'd1);

        // Write presented in a reset cycle is discarded
        reset = 1'b1; wr(2'd0, 16'hBEEF, 3'd7); tick();
        reset = 1'b0; enable_writeback = 1'b0; setrd(0, 3'd7); #1;
        check("reset_write_r7", 32'(rd_data[15:0]), 32'h0);
        check("reset_write_count", 32'(wb_count), 32'h0);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) != 0) begin
                wr(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom), 3'($urandom));
            end else begin
                enable_writeback = 1'b0;
            end
            rd_addr = 9'($urandom);
            if ($urandom_range(0, 2) == 0) setrd(int'($urandom_range(0, NUM_RD-1)), dr);
            tick();
        end
        reset = 1'b0; enable_writeback = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
